// File: rtl/mem_stage.sv
// RISC-V memory stage: E->M register, data-memory handshake with store lane steering,
// load extraction/extension, M->W register. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [2:0]  ResultSrcE,
  input  logic [2:0]  StoreSrcE,
  input  logic [2:0]  LoadSrcE,
  input  logic [4:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  input  logic        MemReady,
  input  logic [31:0] MemRData,
  output logic        StallM,
  output logic        MemErrM,
  output logic        RegWriteM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic        RegWriteW,
  output logic [2:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        fsm_state
);

  localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);
  localparam logic [2:0] RES_LOAD = 3'b001;

  localparam logic [2:0] ST_SW = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SB = 3'b010;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;

  logic        mem_write_m;
  logic [2:0]  result_src_m;
  logic [2:0]  store_src_m;
  logic [2:0]  load_src_m;
  logic [31:0] write_data_m;
  logic [31:0] pc_plus4_m;

  logic        is_load_m;
  logic        access_m;
  logic        misalign_m;
  logic        complete;
  logic        abort;
  logic [1:0]  off;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  // Handshake: MemReq is held until a cycle with MemReady=1 (access done that
  // cycle) or until the wait counter hits TIMEOUT (access abandoned).
  // MemReady is only meaningful while MemReq=1.

  // E->M pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM    <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 3'b000;
      store_src_m  <= 3'b000;
      load_src_m   <= 3'b000;
      RdM          <= 5'd0;
      ALUResultM   <= 32'd0;
      write_data_m <= 32'd0;
      pc_plus4_m   <= 32'd0;
    end else if (!StallM) begin
      RegWriteM    <= RegWriteE;
      mem_write_m  <= MemWriteE;
      result_src_m <= ResultSrcE;
      store_src_m  <= StoreSrcE;
      load_src_m   <= LoadSrcE;
      RdM          <= RdE;
      ALUResultM   <= ALUResultE;
      write_data_m <= WriteDataE;
      pc_plus4_m   <= PCPlus4E;
    end
  end

  assign is_load_m = (result_src_m == RES_LOAD);
  assign access_m  = mem_write_m | is_load_m;
  assign off       = ALUResultM[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign_m = 1'b0;
    if (mem_write_m) begin
      case (store_src_m)
        ST_SH:   misalign_m = ALUResultM[0];
        ST_SW:   misalign_m = |ALUResultM[1:0];
        default: misalign_m = 1'b0;
      endcase
    end else if (is_load_m) begin
      case (load_src_m)
        LD_LH, LD_LHU: misalign_m = ALUResultM[0];
        LD_LW:         misalign_m = |ALUResultM[1:0];
        default:       misalign_m = 1'b0;
      endcase
    end
  end
`else
  assign misalign_m = 1'b0;
`endif

  // Access FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    MemReq     = 1'b0;
    StallM     = 1'b0;
    MemErrM    = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (access_m) begin
          if (misalign_m) begin
            MemErrM = 1'b1;
            abort   = 1'b1;
          end else begin
            MemReq = 1'b1;
            if (MemReady) begin
              complete = 1'b1;
            end else begin
              StallM     = 1'b1;
              cnt_next   = 8'd1;
              state_next = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        MemReq = 1'b1;
        if (MemReady) begin
          complete   = 1'b1;
          cnt_next   = 8'd0;
          state_next = S_IDLE;
        end else if (cnt == TO_CNT) begin
          MemErrM    = 1'b1;
          abort      = 1'b1;
          cnt_next   = 8'd0;
          state_next = S_IDLE;
        end else begin
          StallM   = 1'b1;
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign fsm_state = state;
  assign MemWe     = mem_write_m & MemReq;
  assign MemAddr   = {ALUResultM[31:2], 2'b00};

  // Store lane steering: data is replicated so the enabled lanes always carry it
  always_comb begin
    MemWData = write_data_m;
    MemBe    = 4'b1111;
    if (mem_write_m) begin
      case (store_src_m)
        ST_SB: begin
          MemWData = {4{write_data_m[7:0]}};
          MemBe    = 4'b0001 << off;
        end
        ST_SH: begin
          MemWData = {2{write_data_m[15:0]}};
          MemBe    = 4'b0011 << {off[1], 1'b0};
        end
        ST_SW: begin
          MemWData = write_data_m;
          MemBe    = 4'b1111;
        end
        default: begin
          MemWData = write_data_m;
          MemBe    = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction and extension
  always_comb begin
    rbyte     = MemRData[{off, 3'b000} +: 8];
    rhalf     = off[1] ? MemRData[31:16] : MemRData[15:0];
    load_data = MemRData;
    case (load_src_m)
      LD_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      LD_LBU:  load_data = {24'd0, rbyte};
      LD_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      LD_LHU:  load_data = {16'd0, rhalf};
      LD_LW:   load_data = MemRData;
      default: load_data = MemRData;
    endcase
  end

  // M->W pipeline register; stalled or aborted cycles push a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 3'b000;
      RdW        <= 5'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else if (StallM || abort) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 3'b000;
      RdW        <= 5'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= result_src_m;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (is_load_m && complete) ? load_data : 32'd0;
      PCPlus4W   <= pc_plus4_m;
    end
  end

`ifndef SYNTHESIS
  a_we_needs_req: assert property (@(posedge clk) disable iff (!rst_n) MemWe |-> MemReq);
  a_err_no_stall: assert property (@(posedge clk) disable iff (!rst_n) MemErrM |-> !StallM);
  a_wait_req:     assert property (@(posedge clk) disable iff (!rst_n) (state == S_WAIT) |-> MemReq);
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases from the plan plus randomized
// loads/stores/ALU ops checked against a byte-lane reference model.
module tb_mem_stage;

  localparam int TO = 4;

  localparam logic [2:0] ST_SW = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SB = 3'b010;
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  logic        clk;
  logic        rst_n;
  logic        RegWriteE, MemWriteE;
  logic [2:0]  ResultSrcE, StoreSrcE, LoadSrcE;
  logic [4:0]  RdE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemBe;
  logic        MemReady;
  logic [31:0] MemRData;
  logic        StallM, MemErrM, RegWriteM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic        RegWriteW;
  logic [2:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic        fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .StoreSrcE(StoreSrcE), .LoadSrcE(LoadSrcE), .RdE(RdE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemBe(MemBe), .MemReady(MemReady), .MemRData(MemRData),
    .StallM(StallM), .MemErrM(MemErrM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ALUResultM(ALUResultM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: access size and lane position from the access kind
  function automatic int ld_size(input logic [2:0] k);
    if (k == LD_LB || k == LD_LBU) return 1;
    if (k == LD_LH || k == LD_LHU) return 2;
    return 4;
  endfunction

  function automatic int st_size(input logic [2:0] k);
    if (k == ST_SB) return 1;
    if (k == ST_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] k, input logic [31:0] word, input logic [1:0] o);
    int     sz;
    int     start;
    longint v;
    longint span;
    sz    = ld_size(k);
    start = (int'(o) / sz) * sz;
    span  = longint'(1) << (8 * sz);
    v     = longint'({32'h0, word});
    v     = (v >> (8 * start)) % span;
    if ((k == LD_LB || k == LD_LH) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] k, input logic [1:0] o);
    logic [3:0] be;
    int sz;
    int start;
    sz    = st_size(k);
    start = (int'(o) / sz) * sz;
    for (int i = 0; i < 4; i++) be[i] = (i >= start) && (i < start + sz);
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] k, input logic [31:0] d);
    logic [31:0] w;
    int sz;
    sz = st_size(k);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    RegWriteE  = 1'b0;
    MemWriteE  = 1'b0;
    ResultSrcE = 3'b000;
    StoreSrcE  = 3'b000;
    LoadSrcE   = 3'b000;
    RdE        = 5'd0;
    ALUResultE = $urandom;
    WriteDataE = $urandom;
    PCPlus4E   = $urandom;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
    RegWriteE  = 1'b1;
    MemWriteE  = 1'b0;
    ResultSrcE = 3'b000;
    RdE        = rd;
    ALUResultE = res;
    WriteDataE = $urandom;
    PCPlus4E   = pc;
  endtask

  task automatic drive_load(input logic [2:0] k, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] pc);
    RegWriteE  = 1'b1;
    MemWriteE  = 1'b0;
    ResultSrcE = 3'b001;
    LoadSrcE   = k;
    StoreSrcE  = 3'($urandom_range(0, 2));
    RdE        = rd;
    ALUResultE = a;
    WriteDataE = $urandom;
    PCPlus4E   = pc;
  endtask

  task automatic drive_store(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
    RegWriteE  = 1'b0;
    MemWriteE  = 1'b1;
    ResultSrcE = 3'b000;
    StoreSrcE  = k;
    LoadSrcE   = 3'b000;
    RdE        = 5'($urandom_range(0, 31));
    ALUResultE = a;
    WriteDataE = d;
    PCPlus4E   = $urandom;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n    = 1'b0;
    MemReady = 1'b0;
    MemRData = 32'd0;
    drive_nop();
    #12;
    n_cmp++;
    if ({MemReq, StallM, MemErrM, RegWriteM, RegWriteW, fsm_state} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000", {MemReq, StallM, MemErrM, RegWriteM, RegWriteW, fsm_state});
    end
    n_cmp++;
    if ({RdM, ALUResultM, RdW, ALUResultW, ReadDataW, PCPlus4W, ResultSrcW} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {RdM, ALUResultM, RdW, ALUResultW, ReadDataW, PCPlus4W, ResultSrcW});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    logic [4:0]  rd;
    logic [31:0] res, pc;
    for (int i = 0; i < 10; i++) begin
      rd  = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
      res = (i == 0) ? 32'h1234 : $urandom;
      pc  = $urandom;
      drive_alu(rd, res, pc);
      MemReady = 1'($urandom_range(0, 1));
      MemRData = $urandom;
      tick();
      drive_nop();
      n_cmp++;
      if ({RegWriteM, RdM, ALUResultM} !== {1'b1, rd, res}) begin
        n_err++;
        $display("FAIL pass_m[%0d]: got %h want %h", i, {RegWriteM, RdM, ALUResultM}, {1'b1, rd, res});
      end
      n_cmp++;
      if ({MemReq, StallM, MemErrM} !== 3'b000) begin
        n_err++;
        $display("FAIL pass_noreq[%0d]: got %b want 000", i, {MemReq, StallM, MemErrM});
      end
      tick();
      n_cmp++;
      if ({RegWriteW, RdW, ALUResultW, PCPlus4W, ResultSrcW} !== {1'b1, rd, res, pc, 3'b000}) begin
        n_err++;
        $display("FAIL pass_w[%0d]: got %h want %h", i, {RegWriteW, RdW, ALUResultW, PCPlus4W, ResultSrcW},
                 {1'b1, rd, res, pc, 3'b000});
      end
    end
    MemReady = 1'b0;
  endtask

  task automatic test_load_zero_wait();
    logic [2:0]  k;
    logic [4:0]  rd;
    logic [31:0] a, d, pc, exp;
    int          sz;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        k = LD_LW; a = 32'h100; d = 32'hDEADBEEF;
      end else begin
        k = 3'($urandom_range(0, 4)); d = $urandom; a = $urandom;
        sz = ld_size(k);
        a[1:0] = 2'(($urandom_range(0, 3) / sz) * sz);
      end
      rd  = 5'($urandom_range(1, 31));
      pc  = $urandom;
      exp = ref_load(k, d, a[1:0]);
      drive_load(k, rd, a, pc);
      MemReady = 1'b0;
      tick();
      drive_nop();
      MemReady = 1'b1;
      MemRData = d;
      #1;
      n_cmp++;
      if ({MemReq, MemWe, StallM, MemErrM} !== 4'b1000 || MemAddr !== {a[31:2], 2'b00}) begin
        n_err++;
        $display("FAIL ld0_req[%0d]: got %b addr %h want 1000 addr %h", i, {MemReq, MemWe, StallM, MemErrM},
                 MemAddr, {a[31:2], 2'b00});
      end
      tick();
      MemReady = 1'b0;
      n_cmp++;
      if ({RegWriteW, RdW, ResultSrcW, ReadDataW} !== {1'b1, rd, 3'b001, exp}) begin
        n_err++;
        $display("FAIL ld0_w[%0d] kind %0d: got %h want %h", i, k, {RegWriteW, RdW, ResultSrcW, ReadDataW},
                 {1'b1, rd, 3'b001, exp});
      end
    end
  endtask

  task automatic test_load_wait();
    logic [2:0]  k;
    logic [4:0]  rd, nrd;
    logic [31:0] a, d, pc, nres, exp;
    int          w, sz;
    for (int i = 0; i < 8; i++) begin
      if (i < 2) begin
        k = (i == 0) ? LD_LB : LD_LBU; a = 32'h103; d = 32'h80FF_0000; w = 3;
      end else begin
        k = 3'($urandom_range(0, 4)); d = $urandom; a = $urandom; w = $urandom_range(1, TO);
        sz = ld_size(k);
        a[1:0] = 2'(($urandom_range(0, 3) / sz) * sz);
      end
      rd   = 5'($urandom_range(1, 31));
      nrd  = 5'($urandom_range(1, 31));
      nres = $urandom;
      pc   = $urandom;
      exp  = ref_load(k, d, a[1:0]);
      drive_load(k, rd, a, pc);
      MemReady = 1'b0;
      tick();
      drive_alu(nrd, nres, $urandom);
      for (int c = 0; c < w; c++) begin
        MemRData = $urandom;
        #1;
        n_cmp++;
        if ({MemReq, StallM, MemErrM} !== 3'b110 || RdM !== rd) begin
          n_err++;
          $display("FAIL ldw_stall[%0d.%0d]: got %b rd %0d want 110 rd %0d", i, c, {MemReq, StallM, MemErrM}, RdM, rd);
        end
        tick();
        n_cmp++;
        if (RegWriteW !== 1'b0) begin
          n_err++;
          $display("FAIL ldw_bubble[%0d.%0d]: got %b want 0", i, c, RegWriteW);
        end
      end
      MemReady = 1'b1;
      MemRData = d;
      #1;
      n_cmp++;
      if ({MemReq, StallM} !== 2'b10) begin
        n_err++;
        $display("FAIL ldw_done[%0d]: got %b want 10", i, {MemReq, StallM});
      end
      tick();
      MemReady = 1'b0;
      n_cmp++;
      if ({RegWriteW, RdW, ReadDataW} !== {1'b1, rd, exp}) begin
        n_err++;
        $display("FAIL ldw_w[%0d] kind %0d: got %h want %h", i, k, {RegWriteW, RdW, ReadDataW}, {1'b1, rd, exp});
      end
      n_cmp++;
      if ({RdM, ALUResultM} !== {nrd, nres}) begin
        n_err++;
        $display("FAIL ldw_next_m[%0d]: got %h want %h", i, {RdM, ALUResultM}, {nrd, nres});
      end
      drive_nop();
      tick();
      n_cmp++;
      if ({RegWriteW, RdW, ALUResultW} !== {1'b1, nrd, nres}) begin
        n_err++;
        $display("FAIL ldw_next_w[%0d]: got %h want %h", i, {RegWriteW, RdW, ALUResultW}, {1'b1, nrd, nres});
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  k;
    logic [31:0] a, d;
    int          w, sz;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        k = ST_SH; a = 32'h102; d = 32'h0000_ABCD; w = 0;
      end else begin
        k = 3'($urandom_range(0, 2)); a = $urandom; d = $urandom; w = $urandom_range(0, 2);
        sz = st_size(k);
        a[1:0] = 2'(($urandom_range(0, 3) / sz) * sz);
      end
      drive_store(k, a, d);
      MemReady = 1'b0;
      tick();
      drive_nop();
      for (int c = 0; c < w; c++) begin
        #1;
        n_cmp++;
        if ({MemReq, MemWe, StallM} !== 3'b111) begin
          n_err++;
          $display("FAIL st_stall[%0d.%0d]: got %b want 111", i, c, {MemReq, MemWe, StallM});
        end
        tick();
      end
      MemReady = 1'b1;
      #1;
      n_cmp++;
      if ({MemReq, MemWe, StallM, MemErrM} !== 4'b1100 || MemAddr !== {a[31:2], 2'b00}) begin
        n_err++;
        $display("FAIL st_req[%0d]: got %b addr %h want 1100 addr %h", i, {MemReq, MemWe, StallM, MemErrM},
                 MemAddr, {a[31:2], 2'b00});
      end
      n_cmp++;
      if (MemBe !== ref_be(k, a[1:0]) || MemWData !== ref_wdata(k, d)) begin
        n_err++;
        $display("FAIL st_lanes[%0d] kind %0d: got be %b data %h want be %b data %h", i, k, MemBe, MemWData,
                 ref_be(k, a[1:0]), ref_wdata(k, d));
      end
      tick();
      MemReady = 1'b0;
      n_cmp++;
      if ({RegWriteW, MemReq} !== 2'b00) begin
        n_err++;
        $display("FAIL st_w[%0d]: got %b want 00", i, {RegWriteW, MemReq});
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0]  rd, nrd;
    logic [31:0] a, nres;
    for (int i = 0; i < 2; i++) begin
      rd   = 5'($urandom_range(1, 31));
      nrd  = 5'($urandom_range(1, 31));
      nres = $urandom;
      a    = $urandom;
      a[1:0] = 2'b00;
      drive_load(LD_LW, rd, a, $urandom);
      MemReady = 1'b0;
      tick();
      drive_alu(nrd, nres, $urandom);
      for (int c = 0; c < TO; c++) begin
        #1;
        n_cmp++;
        if ({MemReq, StallM, MemErrM} !== 3'b110) begin
          n_err++;
          $display("FAIL to_stall[%0d.%0d]: got %b want 110", i, c, {MemReq, StallM, MemErrM});
        end
        tick();
        n_cmp++;
        if (RegWriteW !== 1'b0) begin
          n_err++;
          $display("FAIL to_bubble[%0d.%0d]: got %b want 0", i, c, RegWriteW);
        end
      end
      #1;
      n_cmp++;
      if ({StallM, MemErrM} !== 2'b01) begin
        n_err++;
        $display("FAIL to_err[%0d]: got %b want 01", i, {StallM, MemErrM});
      end
      tick();
      n_cmp++;
      if ({RegWriteW, MemErrM, fsm_state, RdM, ALUResultM} !== {3'b000, nrd, nres}) begin
        n_err++;
        $display("FAIL to_after[%0d]: got %h want %h", i, {RegWriteW, MemErrM, fsm_state, RdM, ALUResultM},
                 {3'b000, nrd, nres});
      end
      drive_nop();
      tick();
      n_cmp++;
      if ({RegWriteW, RdW, ALUResultW} !== {1'b1, nrd, nres}) begin
        n_err++;
        $display("FAIL to_next_w[%0d]: got %h want %h", i, {RegWriteW, RdW, ALUResultW}, {1'b1, nrd, nres});
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [4:0]  rd;
    logic [31:0] res;
    drive_load(LD_LW, 5'd9, 32'h0000_0200, 32'h44);
    MemReady = 1'b0;
    tick();
    drive_nop();
    tick();
    n_cmp++;
    if ({MemReq, StallM, fsm_state} !== 3'b111) begin
      n_err++;
      $display("FAIL rst_pre: got %b want 111", {MemReq, StallM, fsm_state});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({MemReq, StallM, MemErrM, RegWriteM, RegWriteW, fsm_state} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_mid_ctrl: got %b want 000000", {MemReq, StallM, MemErrM, RegWriteM, RegWriteW, fsm_state});
    end
    n_cmp++;
    if ({RdM, ALUResultM, RdW, ALUResultW, ReadDataW, PCPlus4W} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_data: got %h want 0", {RdM, ALUResultM, RdW, ALUResultW, ReadDataW, PCPlus4W});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd  = 5'($urandom_range(1, 31));
    res = $urandom;
    drive_alu(rd, res, 32'h80);
    tick();
    drive_nop();
    tick();
    n_cmp++;
    if ({RegWriteW, RdW, ALUResultW} !== {1'b1, rd, res}) begin
      n_err++;
      $display("FAIL rst_recover: got %h want %h", {RegWriteW, RdW, ALUResultW}, {1'b1, rd, res});
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
    drive_load(LD_LW, 5'd7, 32'h0000_0102, 32'h10);
    tick();
    drive_nop();
    MemReady = 1'b1;
    #1;
    n_cmp++;
    if ({MemReq, StallM, MemErrM} !== 3'b001) begin
      n_err++;
      $display("FAIL mis_lw: got %b want 001", {MemReq, StallM, MemErrM});
    end
    tick();
    n_cmp++;
    if ({RegWriteW, MemErrM} !== 2'b00) begin
      n_err++;
      $display("FAIL mis_lw_w: got %b want 00", {RegWriteW, MemErrM});
    end
    drive_store(ST_SH, 32'h0000_0101, 32'h1234_5678);
    MemReady = 1'b0;
    tick();
    drive_nop();
    #1;
    n_cmp++;
    if ({MemReq, MemWe, StallM, MemErrM} !== 4'b0001) begin
      n_err++;
      $display("FAIL mis_sh: got %b want 0001", {MemReq, MemWe, StallM, MemErrM});
    end
    tick();
    n_cmp++;
    if (MemErrM !== 1'b0) begin
      n_err++;
      $display("FAIL mis_sh_pulse: got %b want 0", MemErrM);
    end
`else
    drive_load(LD_LW, 5'd7, 32'h0000_0102, 32'h10);
    tick();
    drive_nop();
    MemReady = 1'b1;
    MemRData = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if ({MemReq, StallM, MemErrM} !== 3'b100 || MemAddr !== 32'h100) begin
      n_err++;
      $display("FAIL unal_lw: got %b addr %h want 100 addr 00000100", {MemReq, StallM, MemErrM}, MemAddr);
    end
    tick();
    n_cmp++;
    if ({RegWriteW, ReadDataW} !== {1'b1, 32'hCAFE_F00D}) begin
      n_err++;
      $display("FAIL unal_lw_w: got %h want 1cafef00d", {RegWriteW, ReadDataW});
    end
`endif
    MemReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_zero_wait();
    test_load_wait();
    test_store();
    test_timeout();
    test_misalign();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline, between the execute stage and writeback.
- Contains the E→M pipeline register, a data-memory request/ready handshake with store lane steering, load extraction and extension, and the M→W pipeline register.
- Drives StallM to the hazard unit while a data access is outstanding.
- Provides RdM, RegWriteM and ALUResultM for forwarding.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for MemReady before aborting the access (range 1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- RegWriteE, MemWriteE  in  1 each  execute-stage controls
- ResultSrcE  in  3  result select; 3'b001 means load
- StoreSrcE  in  3  000 SW, 001 SH, 010 SB
- LoadSrcE  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
- RdE  in  5  destination register
- ALUResultE, WriteDataE, PCPlus4E  in  32 each  execute-stage data
- MemReq  out  1  data-memory request
- MemWe  out  1  write enable
- MemAddr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- MemWData  out  32  lane-steered store data
- MemBe  out  4  byte enables
- MemReady  in  1  memory accepted/completed the access this cycle
- MemRData  in  32  read word, valid when MemReady=1
- StallM  out  1  stall request to the hazard unit
- MemErrM  out  1  one-cycle pulse on timeout (or misalign, if enabled)
- RegWriteM  out  1  forwarding/hazard info
- RdM  out  5  forwarding/hazard info
- ALUResultM  out  32  forwarding/hazard info
- RegWriteW  out  1  writeback control
- ResultSrcW  out  3  writeback control
- RdW  out  5  writeback destination
- ALUResultW, ReadDataW, PCPlus4W  out  32 each  writeback data

Behaviour:
- Reset:
  - All E→M and M→W registers clear to 0, so RegWriteM/W=0 and no access is pending.
  - FSM goes to IDLE, timeout counter to 0, MemReq=0, MemErrM=0.
- E→M register:
  - Loads all E inputs on the rising edge when StallM=0.
  - Holds its value when StallM=1.
- Access:
  - AccessM = MemWriteM | (ResultSrcM==3'b001).
  - Non-access instructions pass through with StallM=0 and one-cycle latency into W.
- FSM:
  - IDLE: if AccessM, assert MemReq. If MemReady the same cycle, the access completes (zero-wait) and StallM=0. Otherwise StallM=1, counter loads 1, next state WAIT.
  - WAIT: MemReq=1, StallM=1, counter increments each cycle. On MemReady the access completes, StallM=0 that cycle, next state IDLE.
  - Timeout: if counter==TIMEOUT without MemReady, abort. MemErrM=1 for one cycle, StallM=0, the W stage receives a bubble (RegWriteW=0), next state IDLE.
  - MemReady is ignored when MemReq=0.
- Store steering (offset = ALUResultM[1:0]):
  - SB: MemWData replicates WriteDataM[7:0] into all four bytes; MemBe = 4'b0001<<offset.
  - SH: MemWData replicates [15:0] into both halves; MemBe = 4'b0011<<(offset[1]*2).
  - SW: MemBe = 4'b1111.
  - MemWe = MemWriteM & MemReq.
- Load extract:
  - Select byte/half by offset from MemRData.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - The result registers into ReadDataW on the completing edge.
- M→W register:
  - Loads when StallM=0.
  - Holds nothing stale: while StallM=1 it loads a bubble (RegWriteW=0) each cycle.
- Misaligned addresses are not checked unless the optional feature is enabled; the low address bits are simply used as the offset.
- rst_n asserted mid-access: the request drops immediately (asynchronous) and the access is lost.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - SH/LH/LHU with ALUResultM[0]=1, or SW/LW with ALUResultM[1:0]!=0, never asserts MemReq.
  - MemErrM pulses for one cycle, StallM=0, the W stage gets a bubble.
- Undefined: no check; behaviour as described in Behaviour.

Test Plan:
- ADD passthrough, RdE=5, ALUResultE=0x1234: one cycle later RdM=5, ALUResultM=0x1234; next cycle RdW=5, RegWriteW=1; MemReq never asserts.
- LW, address 0x100, zero-wait, MemReady=1, MemRData=0xDEADBEEF: StallM stays 0; ReadDataW=0xDEADBEEF next edge.
- LB, address 0x103, MemRData=0x80FF_0000, MemReady after 3 cycles: StallM=1 for 3 cycles; ReadDataW=0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH, address 0x102, WriteDataE=0x0000ABCD: MemBe=4'b1100, MemWData=0xABCDABCD, MemWe=1; RegWriteW=0.
- LW, MemReady held low, TIMEOUT=4: StallM high for 4 cycles, then MemErrM pulses once and RegWriteW=0; FSM returns to IDLE and the next instruction proceeds.
- rst_n pulled low during WAIT: MemReq and StallM drop to 0 asynchronously and all pipeline registers clear. With MEM_MISALIGN_CHECK_EN, LW at 0x102: no MemReq, MemErrM pulses once.
